add_arbiter: RTL
================

ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, operand and sum width.
REQ-002 Parameter ADD_LAT, default 1, range 1..7; cycles from Add_En sampled high to Add_Sum/Add_Overflow valid.
REQ-003 Clk  in  1  single clock, all state on rising edge.
REQ-004 Reset_n  in  1  reset, asynchronous, active-low.
REQ-005 Req0_Valid / Req1_Valid  in  1  requester n has an operand pair.
REQ-006 Req0_A, Req0_B / Req1_A, Req1_B  in  WIDTH  operands of requester n.
REQ-007 Req0_Ready / Req1_Ready  out  1  request accepted when Valid & Ready.
REQ-008 Rsp0_Valid / Rsp1_Valid  out  1  result for requester n available.
REQ-009 Rsp0_Sum / Rsp1_Sum  out  WIDTH; Rsp0_Overflow / Rsp1_Overflow  out  1  result fields.
REQ-010 Rsp0_Ready / Rsp1_Ready  in  1  result consumed when Valid & Ready.
REQ-011 Add_A, Add_B  out  WIDTH; Add_En  out  1  drive the shared adder.
REQ-012 Add_Sum  in  WIDTH; Add_Overflow  in  1  adder results.

Function
REQ-013 The block SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; exactly one transaction in flight.
REQ-014 In IDLE, Req_Ready SHALL be asserted combinationally to the winner only: the sole valid requester, or, if both are valid, the requester selected by priority pointer Prio.
REQ-015 On a Valid & Ready handshake, the block SHALL latch A, B and owner ID, then go to ISSUE; with no valid request it SHALL stay in IDLE.
REQ-016 ISSUE SHALL last exactly 1 cycle, with Add_En = 1 and Add_A/Add_B = latched operands, then go to WAIT.
REQ-017 WAIT SHALL last exactly ADD_LAT cycles; Add_A/Add_B SHALL hold and Add_En = 0.
REQ-018 On the last WAIT cycle, the block SHALL capture Add_Sum and Add_Overflow into result registers, then go to RESP.
REQ-019 In RESP, only the owner's Rsp_Valid SHALL be high, with Sum/Overflow stable until Rsp_Ready; the other requester's Rsp outputs SHALL be 0.
REQ-020 On the RESP handshake, Prio SHALL point to the non-owner, and the FSM SHALL return to IDLE; the next acceptance is possible in that IDLE cycle.
REQ-021 Handshake-to-Rsp_Valid latency SHALL be ADD_LAT+2 cycles; minimum throughput is one op per ADD_LAT+3 cycles.
REQ-022 Req_Ready SHALL be 0 in ISSUE, WAIT and RESP; requests arriving then SHALL wait and SHALL NOT be dropped.
REQ-023 Sum/Overflow SHALL be passed through unmodified; the block SHALL do no arithmetic on operands.
REQ-024 A requester deasserting Valid before its handshake SHALL lose nothing; arbitration SHALL re-evaluate every IDLE cycle.

Reset
REQ-025 While Reset_n = 0, the FSM SHALL be in IDLE, Prio = 0, and latched operands and results = 0.
REQ-026 While Reset_n = 0, all outputs SHALL be 0: Req_Ready, Rsp_Valid, Rsp_Sum, Rsp_Overflow, Add_A, Add_B, Add_En.
REQ-027 Reset asserted mid-transaction SHALL discard it with no response; operation SHALL resume on the first edge after Reset_n rises.

Structure
REQ-028 Shared package add_arbiter_pkg SHALL hold the FSM state typedef (2-bit encoding) and the default WIDTH/ADD_LAT constants.
REQ-029 The 2-way round-robin picker (valids + Prio -> grant one-hot) SHALL be sub-module rr_arb2.
REQ-030 The WAIT counter SHALL be 3 bits wide.

Verification (bench adder model: Sum registered when En, Overflow = unsigned carry-out, ADD_LAT = 1)
REQ-031 Req0 only, A=1111, B=0011, Rsp0_Ready=1 -> Rsp0_Valid 3 cycles after handshake, Sum=0010, Overflow=1; Rsp1_Valid stays 0.
REQ-032 Both valid in the same IDLE cycle after reset (Req0 0001+0010, Req1 0100+0100) -> Req0 served first (Sum=0011); Req1 next (Sum=1000, Overflow=0); Prio=0 after both.
REQ-033 Rsp0_Ready held low 5 cycles -> Rsp0_Valid and Sum held stable; Req1_Ready stays 0 throughout.
REQ-034 Both requesters continuously valid for 6 ops -> grants alternate 0,1,0,1,0,1; one op per 4 cycles.
REQ-035 Reset_n pulsed low during WAIT -> all outputs 0 immediately (asynchronous); no Rsp_Valid for the discarded op; next request after release completes normally.
REQ-036 ADD_LAT=3 build, Req1 0111+0001 -> Add_En high exactly 1 cycle; Rsp1_Valid 5 cycles after handshake with Sum=1000.

Source files
------------

// File: rtl/add_arbiter_pkg.sv
// Shared types and defaults for the two-requester shared-adder arbiter.
// The FSM state is exposed through dbg_state using this encoding.
package add_arbiter_pkg;
    localparam int DEF_WIDTH   = 4;
    localparam int DEF_ADD_LAT = 1;
    localparam int CNT_W       = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;
endpackage

// File: rtl/add_arbiter_if.sv
// Request, response and adder-side signals of add_arbiter.
// Every channel is valid/ready: a transfer happens on a rising Clk edge where Valid and Ready are both high.
interface add_arbiter_if import add_arbiter_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
);
    logic             Req0_Valid, Req0_Ready;
    logic [WIDTH-1:0] Req0_A, Req0_B;
    logic             Req1_Valid, Req1_Ready;
    logic [WIDTH-1:0] Req1_A, Req1_B;

    logic             Rsp0_Valid, Rsp0_Ready, Rsp0_Overflow;
    logic [WIDTH-1:0] Rsp0_Sum;
    logic             Rsp1_Valid, Rsp1_Ready, Rsp1_Overflow;
    logic [WIDTH-1:0] Rsp1_Sum;

    logic [WIDTH-1:0] Add_A, Add_B, Add_Sum;
    logic             Add_En, Add_Overflow;

    modport slave (
        input  Req0_Valid, Req0_A, Req0_B, Req1_Valid, Req1_A, Req1_B,
        input  Rsp0_Ready, Rsp1_Ready, Add_Sum, Add_Overflow,
        output Req0_Ready, Req1_Ready,
        output Rsp0_Valid, Rsp0_Sum, Rsp0_Overflow,
        output Rsp1_Valid, Rsp1_Sum, Rsp1_Overflow,
        output Add_A, Add_B, Add_En
    );

    modport master (
        output Req0_Valid, Req0_A, Req0_B, Req1_Valid, Req1_A, Req1_B,
        output Rsp0_Ready, Rsp1_Ready, Add_Sum, Add_Overflow,
        input  Req0_Ready, Req1_Ready,
        input  Rsp0_Valid, Rsp0_Sum, Rsp0_Overflow,
        input  Rsp1_Valid, Rsp1_Sum, Rsp1_Overflow,
        input  Add_A, Add_B, Add_En
    );
endinterface

// File: rtl/add_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone valid wins outright, a tie goes to the
// requester named by prio. Purely combinational.
module rr_arb2 import add_arbiter_pkg::*; (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant
);
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = prio ? 2'b10 : 2'b01;
        end
    end
endmodule

// File: rtl/add_arbiter.sv
// Arbitrates two requesters onto one external adder, one transaction at a time:
// IDLE (accept) -> ISSUE (pulse Add_En) -> WAIT (ADD_LAT cycles) -> RESP (hold result).
module add_arbiter import add_arbiter_pkg::*; #(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ADD_LAT = DEF_ADD_LAT
) (
    input  logic         Clk,
    input  logic         Reset_n,
    add_arbiter_if.slave bus,
    output arb_state_t   dbg_state,
    output logic         dbg_prio
);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(ADD_LAT - 1);

    arb_state_t       state, state_nx;
    logic             prio, owner, res_ovf;
    logic [WIDTH-1:0] op_a, op_b, res_sum;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       grant;
    logic             accept, rsp_fire;

    rr_arb2 u_rr (
        .valid ({bus.Req1_Valid, bus.Req0_Valid}),
        .prio  (prio),
        .grant (grant)
    );

    // grant is a subset of the valids, so any grant in IDLE is a handshake
    assign accept   = (state == IDLE) && (grant != 2'b00);
    assign rsp_fire = (state == RESP) && (owner ? bus.Rsp1_Ready : bus.Rsp0_Ready);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (wait_cnt == '0) state_nx = RESP;
            RESP:    if (rsp_fire) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            prio     <= 1'b0;
            owner    <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            res_sum  <= '0;
            res_ovf  <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    owner <= grant[1];
                    op_a  <= grant[1] ? bus.Req1_A : bus.Req0_A;
                    op_b  <= grant[1] ? bus.Req1_B : bus.Req0_B;
                end
                ISSUE: wait_cnt <= LAT_M1;
                WAIT: begin
                    if (wait_cnt == '0) begin
                        res_sum <= bus.Add_Sum;
                        res_ovf <= bus.Add_Overflow;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESP: if (rsp_fire) prio <= ~owner;
                default: ;
            endcase
        end
    end

    // Ready is gated by Reset_n so a valid requester sees 0 while reset is held
    always_comb begin
        bus.Req0_Ready    = Reset_n && (state == IDLE) && grant[0];
        bus.Req1_Ready    = Reset_n && (state == IDLE) && grant[1];
        bus.Add_En        = (state == ISSUE);
        bus.Add_A         = '0;
        bus.Add_B         = '0;
        bus.Rsp0_Valid    = 1'b0;
        bus.Rsp0_Sum      = '0;
        bus.Rsp0_Overflow = 1'b0;
        bus.Rsp1_Valid    = 1'b0;
        bus.Rsp1_Sum      = '0;
        bus.Rsp1_Overflow = 1'b0;
        if (state == ISSUE || state == WAIT) begin
            bus.Add_A = op_a;
            bus.Add_B = op_b;
        end
        if (state == RESP) begin
            if (owner) begin
                bus.Rsp1_Valid    = 1'b1;
                bus.Rsp1_Sum      = res_sum;
                bus.Rsp1_Overflow = res_ovf;
            end else begin
                bus.Rsp0_Valid    = 1'b1;
                bus.Rsp0_Sum      = res_sum;
                bus.Rsp0_Overflow = res_ovf;
            end
        end
    end

    assign dbg_state = state;
    assign dbg_prio  = prio;
endmodule
